adc_avg_mv_bcd: RTL and testbench

Downstream consumer of the modular ADC response stream, clocked on the ADC clock-bridge output `sys_clk`. It filters samples by channel and block-averages 2^AVG_LOG2 samples. Each average is converted to millivolts on the 2× divided input (0–4999 mV full scale), then to 4-digit BCD through a sequential double-dabble. Its BCD and average-code outputs feed the HEX display drivers and LEDs, replacing raw hex display of single samples.

---
 rtl/adc_avg_mv_bcd.sv | 167 ++++++++++++++++
 tb/tb_adc_avg_mv_bcd.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_mv_bcd.sv
// Channel-filtered block averager for the ADC response stream: averages 2^AVG_LOG2 samples,
// scales to millivolts (0-4999) and converts to 4-digit BCD with a sequential double-dabble.
module adc_avg_mv_bcd #(
    parameter int unsigned AVG_LOG2 = 4
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic [4:0]  sel_channel,
    input  logic        in_valid,
    input  logic [4:0]  in_channel,
    input  logic [11:0] in_data,
    output logic [11:0] avg_code,
    output logic [15:0] mv_bcd,
    output logic [4:0]  out_channel,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned AccW = 12 + AVG_LOG2;
    localparam int unsigned CntW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {StIdle, StMult, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [4:0]      ch_q;
    logic [AccW-1:0] acc_q;
    logic [CntW-1:0] cnt_q;
    logic            pend_q;
    logic [11:0]     pend_avg_q;
    logic [4:0]      pend_ch_q;
    logic            overrun_q;
    logic [11:0]     avg_q;
    logic [4:0]      cvt_ch_q;
    logic [28:0]     sh_q;
    logic [3:0]      it_q;
    logic [11:0]     avg_code_q;
    logic [15:0]     mv_bcd_q;
    logic [4:0]      out_ch_q;
    logic            out_valid_q;

    logic            ch_change, accept, block_done, take;
    logic [AccW-1:0] sum, sum_avg;
    logic [24:0]     prod;
    logic [15:0]     bcd_adj;

    assign ch_change  = (sel_channel != ch_q);
    assign accept     = !ch_change && in_valid && (in_channel == ch_q);
    assign block_done = accept && (cnt_q == CntLast);
    assign sum        = acc_q + AccW'(in_data);
    assign sum_avg    = sum >> AVG_LOG2;
    assign take       = (state_q == StIdle) && pend_q;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            ch_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_avg_q <= '0;
            pend_ch_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (ch_change) begin
                ch_q  <= sel_channel;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                if (block_done) begin
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    pend_avg_q <= sum_avg[11:0];
                    pend_ch_q  <= ch_q;
                end else begin
                    acc_q <= sum;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            // A fresh average wins over the converter consuming the old one.
            if (block_done) begin
                pend_q <= 1'b1;
            end else if (take) begin
                pend_q <= 1'b0;
            end
            if (block_done && pend_q && !take) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pend_q) state_d = StMult;
            StMult:  state_d = StShift;
            StShift: if (it_q == 4'd12) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign prod = 25'(avg_q) * 25'd5000 + 25'd2048;

    always_comb begin
        bcd_adj = sh_q[28:13];
        for (int i = 0; i < 4; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            avg_q       <= '0;
            cvt_ch_q    <= '0;
            sh_q        <= '0;
            it_q        <= '0;
            avg_code_q  <= '0;
            mv_bcd_q    <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (pend_q) begin
                        avg_q    <= pend_avg_q;
                        cvt_ch_q <= pend_ch_q;
                    end
                end
                StMult: begin
                    // Low 13 bits hold mv, upper 16 bits are the BCD digits being built.
                    sh_q <= {16'd0, prod[24:12]};
                    it_q <= '0;
                end
                StShift: begin
                    sh_q <= {bcd_adj[14:0], sh_q[12:0], 1'b0};
                    it_q <= it_q + 4'd1;
                end
                StDone: begin
                    avg_code_q <= avg_q;
                    mv_bcd_q   <= sh_q[28:13];
                    out_ch_q   <= cvt_ch_q;
                end
                default: ;
            endcase
        end
    end

    assign avg_code    = avg_code_q;
    assign mv_bcd      = mv_bcd_q;
    assign out_channel = out_ch_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != StIdle);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_adc_avg_mv_bcd.sv
// Bench for adc_avg_mv_bcd: a 16-sample instance against a queue-based reference model,
// plus a single-sample instance for overrun and mid-conversion reset.
module tb_adc_avg_mv_bcd;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4_n, v4, rst0_n, v0;
    logic [4:0]  sel4, ch4, sel0, ch0;
    logic [11:0] d4, d0;
    logic [11:0] avg4, avg0;
    logic [15:0] bcd4, bcd0;
    logic [4:0]  och4, och0;
    logic        ov4, busy4, orun4, ov0, busy0, orun0;

    adc_avg_mv_bcd #(.AVG_LOG2(4)) dut4 (
        .sys_clk(clk), .reset_n(rst4_n), .sel_channel(sel4), .in_valid(v4),
        .in_channel(ch4), .in_data(d4), .avg_code(avg4), .mv_bcd(bcd4),
        .out_channel(och4), .out_valid(ov4), .busy(busy4), .overrun(orun4)
    );

    adc_avg_mv_bcd #(.AVG_LOG2(0)) dut0 (
        .sys_clk(clk), .reset_n(rst0_n), .sel_channel(sel0), .in_valid(v0),
        .in_channel(ch0), .in_data(d0), .avg_code(avg0), .mv_bcd(bcd0),
        .out_channel(och0), .out_valid(ov0), .busy(busy0), .overrun(orun0)
    );

    typedef struct {
        int due;
        int avg;
        int bcd;
        int ch;
    } exp_t;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   n_res   = 0;
    int   m_ch    = 0;
    int   blk[$];
    exp_t expq[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int mv_of(input int avg);
        return (avg * 5000 + 2048) / 4096;
    endfunction

    function automatic int bcd_of(input int mv);
        return ((mv / 1000) << 12) | (((mv / 100) % 10) << 8) | (((mv / 10) % 10) << 4) | (mv % 10);
    endfunction

    // Predict what the upcoming edge does to the 16-sample instance, then clock and monitor it.
    task automatic tick();
        exp_t e;
        int   s;
        int   exp_busy;
        if (!rst4_n) begin
            blk.delete();
            expq.delete();
            m_ch = 0;
        end else if (int'(sel4) != m_ch) begin
            blk.delete();
            m_ch = int'(sel4);
        end else if (v4 && int'(ch4) == m_ch) begin
            blk.push_back(int'(d4));
            if (blk.size() == 16) begin
                s = 0;
                foreach (blk[i]) s += blk[i];
                e.avg = s / 16;
                e.bcd = bcd_of(mv_of(e.avg));
                e.ch  = m_ch;
                e.due = cyc + 17;
                expq.push_back(e);
                blk.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ov4) begin
            if (expq.size() == 0) begin
                check_eq("spurious_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                n_res++;
                check_eq("valid_cycle", cyc, e.due);
                check_eq("avg_code", int'(avg4), e.avg);
                check_eq("mv_bcd", int'(bcd4), e.bcd);
                check_eq("out_channel", int'(och4), e.ch);
            end
        end else if (expq.size() > 0 && expq[0].due <= cyc) begin
            check_eq("missing_valid", 0, 1);
            void'(expq.pop_front());
        end
        exp_busy = 0;
        foreach (expq[i]) begin
            if (cyc >= expq[i].due - 15 && cyc <= expq[i].due - 1) exp_busy = 1;
        end
        check_eq("busy", int'(busy4), exp_busy);
    endtask

    task automatic blk4(input int n, input int data, input int ch);
        for (int i = 0; i < n; i++) begin
            v4 = 1'b1; ch4 = 5'(ch); d4 = 12'(data);
            tick();
        end
        v4 = 1'b0;
    endtask

    task automatic drain(input int n);
        v4 = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int r0;
        int a0;
        int found;
        int seen;
        rst4_n = 1'b0; sel4 = '0; v4 = 1'b0; ch4 = '0; d4 = '0;
        rst0_n = 1'b0; sel0 = '0; v0 = 1'b0; ch0 = '0; d0 = '0;
        #1;
        tick();
        tick();
        check_eq("rst_avg", int'(avg4), 0);
        check_eq("rst_bcd", int'(bcd4), 0);
        check_eq("rst_och", int'(och4), 0);
        check_eq("rst_valid", int'(ov4), 0);
        check_eq("rst_overrun", int'(orun4), 0);
        rst4_n = 1'b1;
        sel4 = 5'd1;
        tick();

        blk4(16, 2048, 1);
        drain(20);
        check_eq("b2048_avg", int'(avg4), 2048);
        check_eq("b2048_bcd", int'(bcd4), 16'h2500);
        check_eq("b2048_ch", int'(och4), 1);

        blk4(16, 1000, 1);
        drain(20);
        check_eq("b1000_bcd", int'(bcd4), 16'h1221);
        blk4(16, 4095, 1);
        drain(20);
        check_eq("b4095_bcd", int'(bcd4), 16'h4999);
        blk4(16, 0, 1);
        drain(20);
        check_eq("b0_bcd", int'(bcd4), 16'h0000);
        check_eq("no_overrun", int'(orun4), 0);

        blk4(8, 0, 1);
        blk4(8, 4095, 1);
        drain(20);
        check_eq("mix_avg", int'(avg4), 2047);
        check_eq("mix_bcd", int'(bcd4), 16'h2499);

        r0 = n_res;
        for (int i = 0; i < 16; i++) begin
            blk4(1, 4095, 3);
            blk4(1, 1000, 1);
        end
        drain(20);
        check_eq("ilv_results", n_res - r0, 1);
        check_eq("ilv_bcd", int'(bcd4), 16'h1221);

        r0 = n_res;
        blk4(10, 1000, 1);
        sel4 = 5'd2;
        blk4(1, 2048, 2);
        blk4(16, 2048, 2);
        drain(20);
        check_eq("chg_results", n_res - r0, 1);
        check_eq("chg_ch", int'(och4), 2);
        check_eq("chg_bcd", int'(bcd4), 16'h2500);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(63) == 0) sel4 = 5'($urandom_range(3));
            v4  = ($urandom_range(3) != 0);
            ch4 = ($urandom_range(1) == 1) ? sel4 : 5'($urandom_range(3));
            d4  = 12'($urandom_range(4095));
            tick();
        end
        drain(20);
        check_eq("rand_overrun", int'(orun4), 0);

        // Single-sample instance.
        tick();
        check_eq("d0_rst_bcd", int'(bcd0), 0);
        check_eq("d0_rst_busy", int'(busy0), 0);
        rst0_n = 1'b1;
        sel0 = 5'd1;
        tick();
        v0 = 1'b1; ch0 = 5'd1; d0 = 12'd4095;
        a0 = cyc;
        tick();
        v0 = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            tick();
            if (ov0) begin
                found = 1;
                check_eq("d0_latency", cyc - a0, 17);
                check_eq("d0_avg", int'(avg0), 4095);
                check_eq("d0_bcd", int'(bcd0), 16'h4999);
                check_eq("d0_ch", int'(och0), 1);
            end
        end
        if (found == 0) check_eq("d0_timeout", 0, 1);
        check_eq("d0_overrun_idle", int'(orun0), 0);

        v0 = 1'b1;
        d0 = 12'd100;
        tick();
        d0 = 12'd200;
        tick();
        check_eq("d0_overrun_2nd", int'(orun0), 0);
        d0 = 12'd300;
        tick();
        v0 = 1'b0;
        check_eq("d0_overrun_3rd", int'(orun0), 1);
        tick();
        tick();
        check_eq("d0_busy_shift", int'(busy0), 1);
        rst0_n = 1'b0;
        tick();
        check_eq("d0_mrst_busy", int'(busy0), 0);
        check_eq("d0_mrst_overrun", int'(orun0), 0);
        check_eq("d0_mrst_avg", int'(avg0), 0);
        check_eq("d0_mrst_bcd", int'(bcd0), 0);
        check_eq("d0_mrst_ch", int'(och0), 0);
        check_eq("d0_mrst_valid", int'(ov0), 0);
        rst0_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ov0) seen = 1;
        end
        check_eq("d0_no_valid_after_rst", seen, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
